mult24_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 24-bit shift-add multiplier between NREQ requesters.
- Drives the multiplier through its start/ready handshake:
  - latches the winning requester's operands,
  - pulses start,
  - tracks ready through its busy interval,
  - returns the 48-bit product with a one-cycle done pulse to the owner.
- Sits between requester blocks and the multiplier top level.

---
 rtl/mult24_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mult24_rr_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult24_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one start/ready shift-add multiplier among NREQ requesters.
// Optional watchdog: define MULT24_ARB_TIMEOUT_EN to enable the TIMEOUT_CYC timeout and err pulse.
module mult24_rr_arbiter #(
    parameter int NREQ        = 4,
    parameter int W           = 24,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic [2*W-1:0]      result,
    output logic                busy,
    output logic                m_start,
    output logic [W-1:0]        m_a,
    output logic [W-1:0]        m_b,
    input  logic                m_ready,
    input  logic [2*W-1:0]      m_result,
    output logic                err
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mult24_rr_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    logic [NREQ-1:0] win_onehot;
    logic            issue_now;

`ifdef MULT24_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt;
    logic          timed_out;
    logic          timeout_hit;

    assign timeout_hit = (state == WAIT_BUSY || state == WAIT_DONE) &&
                         (wd_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    // Rotating priority: scan from the requester after the last winner.
    always_comb begin : arbitrate
        logic [PW-1:0] cand;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cand       = '0;
        win_valid  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    assign issue_now = (state == IDLE) && win_valid && m_ready;

    always_comb begin : next_state
        state_next = state;
        unique case (state)
            IDLE:      if (issue_now) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (!m_ready) state_next = WAIT_DONE;
            WAIT_DONE: if (m_ready) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
`ifdef MULT24_ARB_TIMEOUT_EN
        if (timeout_hit) state_next = DONE;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state  <= IDLE;
            ptr    <= PW'(NREQ - 1);
            grant  <= '0;
            m_a    <= '0;
            m_b    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (issue_now) begin
                grant <= win_onehot;
                m_a   <= a_in[int'(win_idx)*W +: W];
                m_b   <= b_in[int'(win_idx)*W +: W];
                ptr   <= win_idx;
            end
            if (state == WAIT_DONE && m_ready) result <= m_result;
            if (state == DONE) grant <= '0;
`ifdef MULT24_ARB_TIMEOUT_EN
            // A genuine completion in the same cycle as the limit wins over the timeout.
            if (timeout_hit && !(state == WAIT_DONE && m_ready)) result <= '0;
`endif
        end
    end

`ifdef MULT24_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (state == ISSUE) begin
            wd_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + TW'(1);
            if (timeout_hit && !(state == WAIT_DONE && m_ready)) timed_out <= 1'b1;
        end
    end

    assign err = (state == DONE) && timed_out;
`else
    assign err = 1'b0;
`endif

    assign busy    = (state != IDLE);
    assign m_start = (state == ISSUE);
    assign done    = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_mult24_rr_arbiter.sv
// Directed bench for mult24_rr_arbiter with a behavioural start/ready multiplier (26 busy cycles).
module tb_mult24_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   a_in;
    logic [NREQ*W-1:0]   b_in;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic [2*W-1:0]      result;
    logic                busy;
    logic                m_start;
    logic [W-1:0]        m_a;
    logic [W-1:0]        m_b;
    logic                m_ready;
    logic [2*W-1:0]      m_result;
    logic                err;

    logic                mult_shares_rst;
    int                  mcnt;
    int                  pass_cnt = 0;
    int                  total    = 0;

    mult24_rr_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .grant    (grant),
        .done     (done),
        .result   (result),
        .busy     (busy),
        .m_start  (m_start),
        .m_a      (m_a),
        .m_b      (m_b),
        .m_ready  (m_ready),
        .m_result (m_result),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: ready drops the cycle after start, returns 26 cycles later with the product.
    always @(posedge clk) begin
        if (rst && mult_shares_rst) begin
            m_ready  <= 1'b1;
            mcnt     <= 0;
            m_result <= '0;
        end else if (m_ready) begin
            if (m_start) begin
                m_ready <= 1'b0;
                mcnt    <= 25;
            end
        end else if (mcnt == 0) begin
            m_ready  <= 1'b1;
            m_result <= 48'(m_a) * 48'(m_b);
        end else begin
            mcnt <= mcnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs one operation from the current point (#1 after an edge) up to its done pulse.
    task automatic run_op(input string name, input logic [3:0] exp_g, input int exp_cyc,
                          input logic [47:0] exp_r);
        int         n;
        int         starts;
        int         start_edge;
        logic [3:0] g_at_start;
        logic       seen;
        n = 0; starts = 0; start_edge = -1; g_at_start = '0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (m_start) begin
                starts++;
                start_edge = n;
                g_at_start = grant;
            end
            if (done != '0) seen = 1'b1;
        end
        check({name, "_start_cnt"},  64'(starts),     64'd1);
        check({name, "_start_edge"}, 64'(start_edge), 64'(exp_cyc - 28));
        check({name, "_grant"},      64'(g_at_start), 64'(exp_g));
        check({name, "_latency"},    64'(n),          64'(exp_cyc));
        check({name, "_done"},       64'(done),       64'(exp_g));
        check({name, "_grant_held"}, 64'(grant),      64'(exp_g));
        check({name, "_result"},     64'(result),     64'(exp_r));
    endtask

    typedef struct {
        logic              gap;
        logic [NREQ-1:0]   req;
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        logic [NREQ-1:0]   exp_g;
        logic [2*W-1:0]    exp_r;
    } vec_t;

    localparam logic [NREQ*W-1:0] A_C = {24'h800000, 24'h123456, 24'd1000, 24'd10};
    localparam logic [NREQ*W-1:0] B_C = {24'h800000, 24'd2,      24'd3000, 24'd20};

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic ok;

        vecs[0] = '{1'b1, 4'b0001, 96'd3, 96'd5, 4'b0001, 48'd15};
        vecs[1] = '{1'b0, 4'b0100, {24'h0, 24'hFFFFFF, 48'h0}, {24'h0, 24'hFFFFFF, 48'h0},
                    4'b0100, 48'hFFFFFE000001};
        vecs[2] = '{1'b0, 4'b1000, {24'hABCDEF, 72'h0}, {24'd1, 72'h0}, 4'b1000, 48'hABCDEF};
        vecs[3] = '{1'b0, 4'b1111, A_C, B_C, 4'b0001, 48'd200};
        vecs[4] = '{1'b0, 4'b1111, A_C, B_C, 4'b0010, 48'd3000000};
        vecs[5] = '{1'b0, 4'b1111, A_C, B_C, 4'b0100, 48'h2468AC};
        vecs[6] = '{1'b0, 4'b1111, A_C, B_C, 4'b1000, 48'h400000000000};
        vecs[7] = '{1'b0, 4'b1111, A_C, B_C, 4'b0001, 48'd200};
        vecs[8] = '{1'b1, 4'b0010, A_C, B_C, 4'b0010, 48'd3000000};
        vecs[9] = '{1'b1, 4'b0011, A_C, B_C, 4'b0001, 48'd200};

        mult_shares_rst = 1'b1;
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",   64'(grant),   64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_result",  64'(result),  64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_m_start", 64'(m_start), 64'd0);
        check("rst_m_a",     64'(m_a),     64'd0);
        check("rst_m_b",     64'(m_b),     64'd0);
        check("rst_err",     64'(err),     64'd0);
        rst = 1'b0;

        // Each vector is driven #1 after the previous done edge, or after an idle gap.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].gap) begin
                req = '0;
                repeat (3) @(posedge clk);
                #1;
            end
            req  = vecs[i].req;
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            run_op($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].gap ? 29 : 30, vecs[i].exp_r);
        end
        req = '0;
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done),  64'd0);
        check("grant_cleared",  64'(grant), 64'd0);
        check("idle_not_busy",  64'(busy),  64'd0);
        check("result_held",    64'(result), 64'd200);

        // Shared reset during WAIT_DONE.
        req  = 4'b0001;
        a_in = 96'd3;
        b_in = 96'd5;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_grant",   64'(grant),   64'd0);
        check("midrst_done",    64'(done),    64'd0);
        check("midrst_result",  64'(result),  64'd0);
        check("midrst_busy",    64'(busy),    64'd0);
        check("midrst_m_start", 64'(m_start), 64'd0);
        check("midrst_m_a",     64'(m_a),     64'd0);
        check("midrst_err",     64'(err),     64'd0);
        ok = 1'b1;
        repeat (35) begin
            @(posedge clk); #1;
            if (done != '0 || busy) ok = 1'b0;
        end
        check("midrst_quiet", 64'(ok), 64'd1);
        req = 4'b0001;
        run_op("post_rst", 4'b0001, 29, 48'd15);
        req = '0;
        repeat (2) @(posedge clk);
        #1;

        // Arbiter-only reset: multiplier stays busy, so no grant until m_ready returns.
        a_in = A_C;
        b_in = B_C;
        req  = 4'b0010;
        repeat (10) @(posedge clk);
        #1;
        mult_shares_rst = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("arbrst_grant", 64'(grant), 64'd0);
        check("arbrst_busy",  64'(busy),  64'd0);
        ok = 1'b1;
        n  = 0;
        while (!m_ready && n < 60) begin
            if (grant != '0 || busy) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("arbrst_hold_no_grant", 64'(ok),      64'd1);
        check("arbrst_mult_recovers", 64'(m_ready), 64'd1);
        run_op("arbrst_op", 4'b0010, 29, 48'd3000000);
        mult_shares_rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        check("final_done_low", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
